// File: rtl/hough_peak_select_pkg.sv
// Shared widths, peak record and controller state encoding for the Hough peak selector.
package hough_pkg;

  localparam int ACC_W           = 8;
  localparam int THETA_BITS      = 9;
  localparam int RHO_BITS        = 16;
  localparam int DEF_LANES       = 16;
  localparam int DEF_THETAS      = 180;
  localparam int DEF_THETA_SPLIT = 90;
  localparam int DEF_TOP_K       = 2;

  typedef struct packed {
    logic                  valid;
    logic [ACC_W-1:0]      votes;
    logic [RHO_BITS-1:0]   rho;
    logic [THETA_BITS-1:0] theta;
  } peak_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/hough_peak_select_if.sv
// Accumulator readout stream: one row of LANES theta bins per beat.
interface hough_peak_select_if
  import hough_pkg::*;
#(
  parameter int LANES = DEF_LANES
) ();

  logic                              in_valid;
  logic                              in_ready;
  logic [0:LANES-1][ACC_W-1:0]       in_data;
  logic [RHO_BITS-1:0]               in_rho;
  logic [THETA_BITS-1:0]             in_theta_base;
  logic                              in_last;

  modport master (
    output in_valid, in_data, in_rho, in_theta_base, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_rho, in_theta_base, in_last,
    output in_ready
  );

endinterface

// File: rtl/hough_peak_select_topk_insert.sv
// One region's sorted top-K peak list; slot 0 holds the highest vote count.
module hough_topk_insert
  import hough_pkg::*;
#(
  parameter int TOP_K = DEF_TOP_K
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  peak_t                 cand,
  output peak_t [TOP_K-1:0]     list
);

  peak_t [TOP_K-1:0] nxt;
  int                pos;
  logic              hit;

  // Strict compare places an equal-vote candidate after existing equals.
  always_comb begin
    nxt = list;
    hit = 1'b0;
    pos = TOP_K;
    for (int k = TOP_K - 1; k >= 0; k--) begin
      if (!list[k].valid || (cand.votes > list[k].votes)) begin
        hit = 1'b1;
        pos = k;
      end
    end
    if (cand.valid && hit) begin
      for (int k = 1; k < TOP_K; k++) begin
        if (k == pos) begin
          nxt[k] = cand;
        end else if (k > pos) begin
          nxt[k] = list[k-1];
        end
      end
      if (pos == 0) begin
        nxt[0] = cand;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      list <= '0;
    end else if (clear) begin
      list <= '0;
    end else begin
      list <= nxt;
    end
  end

endmodule

// File: rtl/hough_peak_select.sv
// Streaming top-K vote peak selector, split into right (low theta) and left (high theta) regions.
// state   | meaning
// S_IDLE  | waiting for start, results held
// S_SCAN  | accepting beats until in_last
// S_DRAIN | two-cycle flush of reduce/insert pipeline
// S_DONE  | done pulse, results final
module hough_peak_select
  import hough_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int THETAS      = DEF_THETAS,
  parameter int THETA_SPLIT = DEF_THETA_SPLIT,
  parameter int TOP_K       = DEF_TOP_K
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ACC_W-1:0]                     threshold,
  hough_peak_select_if.slave                   stream,
  output logic                                 busy,
  output logic                                 done,
  output logic [TOP_K-1:0]                     left_valid,
  output logic [TOP_K-1:0]                     right_valid,
  output logic [TOP_K-1:0][ACC_W-1:0]          left_votes,
  output logic [TOP_K-1:0][ACC_W-1:0]          right_votes,
  output logic [TOP_K-1:0][RHO_BITS-1:0]       left_rho,
  output logic [TOP_K-1:0][RHO_BITS-1:0]       right_rho,
  output logic [TOP_K-1:0][THETA_BITS-1:0]     left_theta,
  output logic [TOP_K-1:0][THETA_BITS-1:0]     right_theta
);

  localparam logic [0:0] DRAIN_LOAD = 1'b1;

  state_t            state;
  logic [0:0]        drain_cnt;
  logic              ready_q;
  logic [ACC_W-1:0]  thr_q;
  logic              accept;
  logic              clear;
  peak_t             best_r, best_l, cand_r, cand_l;
  peak_t [TOP_K-1:0] list_r, list_l;

  assign stream.in_ready = ready_q;
  assign accept          = stream.in_valid && ready_q;
  assign clear           = start && (state == S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
      thr_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SCAN;
            ready_q <= 1'b1;
            busy    <= 1'b1;
            thr_q   <= threshold;
          end
        end
        S_SCAN: begin
          if (accept && stream.in_last) begin
            state     <= S_DRAIN;
            ready_q   <= 1'b0;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat reduce: one candidate per region, lowest theta wins a vote tie.
  always_comb begin
    best_r = '0;
    best_l = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [THETA_BITS:0] t;
      t = {1'b0, stream.in_theta_base} + (THETA_BITS+1)'(l);
      if ((t < (THETA_BITS+1)'(THETAS)) && (stream.in_data[l] >= thr_q)) begin
        if (t < (THETA_BITS+1)'(THETA_SPLIT)) begin
          if (!best_r.valid || (stream.in_data[l] > best_r.votes)) begin
            best_r.valid = 1'b1;
            best_r.votes = stream.in_data[l];
            best_r.rho   = stream.in_rho;
            best_r.theta = t[THETA_BITS-1:0];
          end
        end else begin
          if (!best_l.valid || (stream.in_data[l] > best_l.votes)) begin
            best_l.valid = 1'b1;
            best_l.votes = stream.in_data[l];
            best_l.rho   = stream.in_rho;
            best_l.theta = t[THETA_BITS-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_r <= '0;
      cand_l <= '0;
    end else begin
      cand_r <= accept ? best_r : '0;
      cand_l <= accept ? best_l : '0;
    end
  end

  hough_topk_insert #(.TOP_K(TOP_K)) u_right (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .cand  (cand_r),
    .list  (list_r)
  );

  hough_topk_insert #(.TOP_K(TOP_K)) u_left (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .cand  (cand_l),
    .list  (list_l)
  );

  always_comb begin
    for (int k = 0; k < TOP_K; k++) begin
      right_valid[k] = list_r[k].valid;
      right_votes[k] = list_r[k].votes;
      right_rho[k]   = list_r[k].rho;
      right_theta[k] = list_r[k].theta;
      left_valid[k]  = list_l[k].valid;
      left_votes[k]  = list_l[k].votes;
      left_rho[k]    = list_l[k].rho;
      left_theta[k]  = list_l[k].theta;
    end
  end

endmodule

// File: tb/tb_hough_peak_select.sv
// Directed and randomized frames checked against a collect-then-rank reference model.
module tb_hough_peak_select;
  import hough_pkg::*;

  localparam int LANES  = 16;
  localparam int K      = 2;
  localparam int THETAS = 180;
  localparam int SPLIT  = 90;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic [ACC_W-1:0] threshold;
  logic busy, done;
  logic [K-1:0] left_valid, right_valid;
  logic [K-1:0][ACC_W-1:0] left_votes, right_votes;
  logic [K-1:0][RHO_BITS-1:0] left_rho, right_rho;
  logic [K-1:0][THETA_BITS-1:0] left_theta, right_theta;

  hough_peak_select_if #(.LANES(LANES)) bus ();

  hough_peak_select #(
    .LANES(LANES), .THETAS(THETAS), .THETA_SPLIT(SPLIT), .TOP_K(K)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .threshold   (threshold),
    .stream      (bus.slave),
    .busy        (busy),
    .done        (done),
    .left_valid  (left_valid),
    .right_valid (right_valid),
    .left_votes  (left_votes),
    .right_votes (right_votes),
    .left_rho    (left_rho),
    .right_rho   (right_rho),
    .left_theta  (left_theta),
    .right_theta (right_theta)
  );

  always #5 clock = ~clock;

  typedef struct {
    int votes;
    int rho;
    int theta;
  } cand_t;

  cand_t q_right[$];
  cand_t q_left[$];
  int    exp_valid [2][K];
  int    exp_votes [2][K];
  int    exp_rho   [2][K];
  int    exp_theta [2][K];
  int    m_thr;
  bit    m_scan;
  int    checks = 0;
  int    errors = 0;
  logic [ACC_W-1:0] beat_v [LANES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_beat();
    for (int l = 0; l < LANES; l++) beat_v[l] = '0;
  endtask

  // Reference: each beat contributes its best qualifying bin per region.
  task automatic model_beat(input int base, input int rho);
    int rb, lb;
    rb = -1;
    lb = -1;
    for (int l = 0; l < LANES; l++) begin
      int th;
      th = base + l;
      if (th < THETAS && int'(beat_v[l]) >= m_thr) begin
        if (th < SPLIT) begin
          if (rb < 0 || beat_v[l] > beat_v[rb]) rb = l;
        end else begin
          if (lb < 0 || beat_v[l] > beat_v[lb]) lb = l;
        end
      end
    end
    if (rb >= 0) q_right.push_back('{int'(beat_v[rb]), rho, base + rb});
    if (lb >= 0) q_left.push_back('{int'(beat_v[lb]), rho, base + lb});
  endtask

  // Rank all candidates of a region: highest votes first, earliest arrival on ties.
  task automatic pick(input cand_t q[$], input int r);
    bit taken[$];
    for (int i = 0; i < q.size(); i++) taken.push_back(1'b0);
    for (int k = 0; k < K; k++) begin
      int b;
      b = -1;
      for (int i = 0; i < q.size(); i++)
        if (!taken[i] && (b < 0 || q[i].votes > q[b].votes)) b = i;
      if (b >= 0) begin
        taken[b] = 1'b1;
        exp_valid[r][k] = 1;
        exp_votes[r][k] = q[b].votes;
        exp_rho[r][k]   = q[b].rho;
        exp_theta[r][k] = q[b].theta;
      end else begin
        exp_valid[r][k] = 0;
        exp_votes[r][k] = 0;
        exp_rho[r][k]   = 0;
        exp_theta[r][k] = 0;
      end
    end
  endtask

  task automatic build_expected();
    pick(q_right, 0);
    pick(q_left, 1);
  endtask

  task automatic check_lists(input string tag);
    for (int k = 0; k < K; k++) begin
      chk($sformatf("%s_r%0d_valid", tag, k), 32'(right_valid[k]), exp_valid[0][k]);
      chk($sformatf("%s_r%0d_votes", tag, k), 32'(right_votes[k]), exp_votes[0][k]);
      chk($sformatf("%s_r%0d_rho", tag, k), 32'($signed(right_rho[k])), exp_rho[0][k]);
      chk($sformatf("%s_r%0d_theta", tag, k), 32'(right_theta[k]), exp_theta[0][k]);
      chk($sformatf("%s_l%0d_valid", tag, k), 32'(left_valid[k]), exp_valid[1][k]);
      chk($sformatf("%s_l%0d_votes", tag, k), 32'(left_votes[k]), exp_votes[1][k]);
      chk($sformatf("%s_l%0d_rho", tag, k), 32'($signed(left_rho[k])), exp_rho[1][k]);
      chk($sformatf("%s_l%0d_theta", tag, k), 32'(left_theta[k]), exp_theta[1][k]);
    end
  endtask

  task automatic start_frame(input int thr);
    start     = 1'b1;
    threshold = ACC_W'(thr);
    @(posedge clock); #1;
    start  = 1'b0;
    m_thr  = thr;
    m_scan = 1'b1;
    q_right.delete();
    q_left.delete();
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic send_beat(input int base, input int rho, input bit last);
    bus.in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) bus.in_data[l] = beat_v[l];
    bus.in_rho        = RHO_BITS'(rho);
    bus.in_theta_base = THETA_BITS'(base);
    bus.in_last       = last;
    chk("beat_ready", 32'(bus.in_ready), 32'(m_scan));
    if (m_scan) begin
      model_beat(base, rho);
      if (last) m_scan = 1'b0;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  // Entered in the cycle after in_last was accepted; in_valid is left as the last beat drove it.
  task automatic finish_frame(input string tag);
    int k;
    chk("ready_drop", 32'(bus.in_ready), 0);
    k = 1;
    while (done !== 1'b1 && k < 12) begin
      @(posedge clock); #1;
      k++;
    end
    chk("done_latency", k, 3);
    chk("done_busy", 32'(busy), 1);
    build_expected();
    check_lists(tag);
    start     = 1'b1;
    threshold = ACC_W'($urandom_range(0, 255));
    @(posedge clock); #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_ready", 32'(bus.in_ready), 0);
    check_lists({tag, "_hold"});
  endtask

  task automatic single_peak_frame(input string tag);
    start_frame(1);
    clear_beat();
    send_beat(0, 3, 1'b0);
    beat_v[0] = 8'd200;
    send_beat(128, -163, 1'b0);
    clear_beat();
    beat_v[12] = 8'd150;
    send_beat(48, 575, 1'b0);
    clear_beat();
    send_beat(96, -1, 1'b1);
    finish_frame(tag);
    chk("sp_l0_votes", 32'(left_votes[0]), 200);
    chk("sp_l0_rho", 32'($signed(left_rho[0])), -163);
    chk("sp_l0_theta", 32'(left_theta[0]), 128);
    chk("sp_r0_votes", 32'(right_votes[0]), 150);
    chk("sp_r0_rho", 32'($signed(right_rho[0])), 575);
    chk("sp_r0_theta", 32'(right_theta[0]), 60);
    chk("sp_l1_valid", 32'(left_valid[1]), 0);
    chk("sp_r1_valid", 32'(right_valid[1]), 0);
  endtask

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    threshold         = '0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.in_rho        = '0;
    bus.in_theta_base = '0;
    bus.in_last       = 1'b0;
    m_scan            = 1'b0;
    m_thr             = 0;
    clear_beat();
    @(posedge clock); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_rvalid", 32'(right_valid), 0);
    chk("rst_lvotes", 32'(left_votes), 0);
    chk("rst_rrho", 32'(right_rho), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    single_peak_frame("single");

    // in_valid while idle must not disturb held results
    bus.in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) bus.in_data[l] = 8'd255;
    bus.in_theta_base = 9'd0;
    bus.in_last       = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_lists("idle_ignore");

    start_frame(1);
    clear_beat(); beat_v[10] = 8'd50;
    send_beat(0, 1, 1'b0);
    clear_beat(); beat_v[10] = 8'd90;
    send_beat(0, 2, 1'b0);
    clear_beat(); beat_v[10] = 8'd70;
    send_beat(0, 3, 1'b1);
    finish_frame("topk");
    chk("topk_r0", 32'(right_votes[0]), 90);
    chk("topk_r1", 32'(right_votes[1]), 70);

    start_frame(1);
    clear_beat(); beat_v[14] = 8'd80;
    send_beat(16, -5, 1'b0);
    send_beat(16, 10, 1'b1);
    finish_frame("tie");
    chk("tie_r0_rho", 32'($signed(right_rho[0])), -5);
    chk("tie_r1_rho", 32'($signed(right_rho[1])), 10);

    start_frame(1);
    clear_beat(); beat_v[14] = 8'd80;
    send_beat(16, -5, 1'b0);
    send_beat(16, 10, 1'b0);
    clear_beat(); beat_v[4] = 8'd99; beat_v[5] = 8'd99;
    send_beat(16, 7, 1'b1);
    finish_frame("supp");
    chk("supp_r0_theta", 32'(right_theta[0]), 20);
    chk("supp_r0_votes", 32'(right_votes[0]), 99);
    chk("supp_r1_theta", 32'(right_theta[1]), 30);
    chk("supp_r1_rho", 32'($signed(right_rho[1])), -5);

    start_frame(1);
    clear_beat();
    for (int l = 4; l < LANES; l++) beat_v[l] = 8'd255;
    send_beat(176, 9, 1'b1);
    finish_frame("mask_theta");
    chk("mask_theta_r", 32'(right_valid), 0);
    chk("mask_theta_l", 32'(left_valid), 0);

    start_frame(31);
    for (int l = 0; l < LANES; l++) beat_v[l] = 8'd30;
    send_beat(80, 4, 1'b1);
    finish_frame("mask_thr");
    chk("mask_thr_r", 32'(right_valid), 0);
    chk("mask_thr_l", 32'(left_valid), 0);

    // Reset mid-frame, then a fresh frame
    start_frame(5);
    for (int l = 0; l < LANES; l++) beat_v[l] = ACC_W'($urandom_range(0, 255));
    send_beat(32, 100, 1'b0);
    send_beat(112, -100, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    chk("mid_rst_rvalid", 32'(right_valid), 0);
    chk("mid_rst_lvalid", 32'(left_valid), 0);
    chk("mid_rst_lvotes", 32'(left_votes), 0);
    chk("mid_rst_ltheta", 32'(left_theta), 0);
    bus.in_valid = 1'b0;
    m_scan       = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_nodone", 32'(done), 0);
      @(posedge clock); #1;
    end
    single_peak_frame("after_rst");

    for (int f = 0; f < 25; f++) begin
      int nb;
      start_frame($urandom_range(0, 120));
      nb = $urandom_range(1, 14);
      for (int b = 0; b < nb; b++) begin
        for (int l = 0; l < LANES; l++) begin
          case ($urandom_range(0, 3))
            0:       beat_v[l] = ACC_W'($urandom_range(0, 255));
            1:       beat_v[l] = ACC_W'(40 + 20 * $urandom_range(0, 3));
            default: beat_v[l] = ACC_W'($urandom_range(0, 40));
          endcase
        end
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send_beat($urandom_range(0, 190), int'($urandom_range(0, 65535)) - 32768, b == nb - 1);
      end
      finish_frame($sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hough_peak_select.md
# hough_peak_select

Streaming peak selector between the Hough accumulator readout and the lane-line fit stage. It consumes accumulator rows, LANES theta bins per beat, and splits bins into a right region and a left region by theta. For each region it keeps a sorted top-K list of vote peaks with their rho and theta. This generalises the previous single left/right peak to K peaks, a runtime vote threshold and a configurable lane count.

## Interface
- LANES, 16, theta bins per input beat
- ACC_W, 8, accumulator vote width
- THETAS, 180, number of theta bins
- THETA_BITS, 9, theta index width
- RHO_BITS, 16, signed rho width
- TOP_K, 2, peaks kept per region (1..8)
- THETA_SPLIT, 90, bins with theta < THETA_SPLIT are right; theta >= THETA_SPLIT are left
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; clears both lists and enters SCAN
- threshold  in  ACC_W  minimum votes for a bin to qualify; sampled on start
- in_valid  in  1  input beat valid
- in_ready  out  1  high only in SCAN
- in_data  in  [0:LANES-1][ACC_W]  votes; lane l is theta in_theta_base+l
- in_rho  in  RHO_BITS signed  rho of the beat
- in_theta_base  in  THETA_BITS  theta of lane 0
- in_last  in  1  final beat of the frame
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse when results are final
- left_valid, right_valid  out  TOP_K  per-slot occupied flags
- left_votes, right_votes  out  [TOP_K][ACC_W]  slot votes, slot 0 highest
- left_rho, right_rho  out  [TOP_K][RHO_BITS]  slot rho, signed
- left_theta, right_theta  out  [TOP_K][THETA_BITS]  slot theta

## Operation
- States:
  - IDLE: start -> SCAN.
  - SCAN: a beat is accepted when in_valid && in_ready. An accepted beat with in_last -> DRAIN.
  - DRAIN: 2 cycles of pipeline flush -> DONE.
  - DONE: one cycle with done=1 -> IDLE.
- start is ignored unless the state is IDLE.
- start clears all valid/votes/rho/theta slots to 0 and latches threshold.
- Lane masking:
  - A lane is masked if in_theta_base+l >= THETAS.
  - A lane is masked if its votes < threshold.
  - Masked lanes never become candidates.
- Stage 1 (beat reduce):
  - Per region, picks the max-vote unmasked lane in the beat; on a tie the lowest theta wins.
  - Output is at most one candidate per region per beat. This is intentional coarse non-maximum suppression.
- Stage 2 (insert):
  - A candidate is inserted into the region's sorted list if its votes are strictly greater than some slot's votes, or if an empty slot exists.
  - Lower slots shift down and the last slot drops.
  - An equal-vote candidate goes after existing equals, so the earliest arrival wins ties.
- Results hold after done until the next start.
- in_valid while in_ready=0 is ignored, with no side effects.

## Timing
- Reset values: state IDLE; in_ready=0, busy=0, done=0; all list slots (valid, votes, rho, theta) = 0.
- Reset asserted mid-frame aborts immediately with the same reset values; no done pulse.
- Throughput: one beat per cycle in SCAN.
- Beat accepted at cycle T: stage 1 registered at T+1, list updated at T+2.
- in_last accepted at T:
  - in_ready drops at T+1.
  - done=1 at T+3, with outputs already final.
  - busy falls at T+4.
- A start in the same cycle as done is ignored.
- busy rises the cycle after start.
- Widths: votes are compared unsigned; rho passes through unmodified; theta = in_theta_base + l, with THETA_BITS+1-bit compare against THETAS.

## Structure
- hough_pkg holds:
  - peak_t struct {valid, votes, rho, theta};
  - the state enum;
  - defaults for LANES, ACC_W, THETAS, THETA_BITS and RHO_BITS, shared with hough_top.
- Sub-module hough_topk_insert: one sorted list plus the insertion logic, parameterised by TOP_K, instantiated per region (twice).

## Test plan
- Single peak:
  - Stimulus: all zeros except rho=-163, theta=128 with 200 votes, and rho=575, theta=60 with 150 votes; threshold=1.
  - Required: left slot 0 = (200, -163, 128); right slot 0 = (150, 575, 60); slot 1 valid=0 in both regions.
- Top-K ordering, TOP_K=2, right region:
  - Stimulus: 50, 90, 70 votes in separate beats.
  - Required: right slot 0 = 90, slot 1 = 70.
- Ties and suppression:
  - Stimulus: two beats each with 80 votes, at rho -5 then rho 10. Then one beat with theta 20 and theta 21 both at 99.
  - Required: after the tied beats, slot 0 = rho -5. After the same-beat pair, only theta 20 is listed from that beat.
- Masking:
  - Stimulus: theta_base=176 with LANES=16; 255 votes on lanes with theta >= 180. Separately, 30 votes with threshold=31.
  - Required: both lists empty.
- Timing:
  - Stimulus: in_last at cycle T.
  - Required: done high exactly at T+3; in_valid held high after T has no effect.
- Reset:
  - Stimulus: assert reset mid-frame, then start a fresh frame.
  - Required: outputs all zero with no done pulse; the fresh frame produces results identical to the single-peak case.
